i2s_tx_controller: RTL

//  Audio-domain I2S transmitter: the stage directly downstream of the CPU->audio async FIFO in z1top.

---
 rtl/i2s_tx_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_controller.sv
// i2s_tx_controller: Philips-format I2S transmitter for the audio clock domain.
// Takes left/right PCM samples over valid/ready handshakes, divides clk down to
// MCLK/SCLK/LRCK and shifts each sample out MSB-first on SDIN. The MSB lands one
// SCLK after each LRCK edge.
// Ports:
//   clk          audio-domain clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   pcm_data     sample bus shared by both channels
//   left_valid   pcm_data holds a left sample
//   left_ready   left holding register empty
//   right_valid  pcm_data holds a right sample
//   right_ready  right holding register empty and no competing left request
//   mclk         master clock to codec
//   sclk         serial bit clock
//   lrck         word select (0 = left slot, 1 = right slot)
//   sdin         serial data to codec
//   underflow    one-clk pulse when a slot starts with an empty holding register
module i2s_tx_controller #(
   parameter int unsigned BIT_DEPTH = 24,
   parameter int unsigned MCLK_HALF = 1,
   parameter int unsigned SCLK_HALF = 4,
   parameter int unsigned SLOT_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BIT_DEPTH-1:0] pcm_data,
   input  logic                 left_valid,
   output logic                 left_ready,
   input  logic                 right_valid,
   output logic                 right_ready,
   output logic                 mclk,
   output logic                 sclk,
   output logic                 lrck,
   output logic                 sdin,
   output logic                 underflow
);

   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
   localparam int unsigned MDIV_W     = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
   localparam int unsigned SDIV_W     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

   logic [MDIV_W-1:0]    mdiv_q, mdiv_d;
   logic [SDIV_W-1:0]    sdiv_q, sdiv_d;
   logic                 mclk_q, mclk_d;
   logic                 sclk_q, sclk_d;
   logic                 lrck_q, lrck_d;
   logic                 sdin_q, sdin_d;
   logic                 underflow_q, underflow_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [BIT_DEPTH-1:0] shift_q, shift_d;
   logic [BIT_DEPTH-1:0] left_hold_q, left_hold_d;
   logic [BIT_DEPTH-1:0] right_hold_q, right_hold_d;
   logic                 left_full_q, left_full_d;
   logic                 right_full_q, right_full_d;

   logic                 mdiv_tick, sdiv_tick, fall_evt;
   logic [CNT_W-1:0]     bit_cnt_nxt, slot_pos;
   logic                 load_left, load_right;
   logic                 left_xfer, right_xfer;
   logic                 right_ready_c;

   // Left has priority on the shared bus, so right cannot accept while left requests.
   assign right_ready_c = !right_full_q && !left_valid;
   assign left_ready    = !left_full_q;
   assign right_ready   = right_ready_c;
   assign mclk          = mclk_q;
   assign sclk          = sclk_q;
   assign lrck          = lrck_q;
   assign sdin          = sdin_q;
   assign underflow     = underflow_q;

   // Next-state logic: dividers, bit counter, slot loads, serialiser and holders.
   always_comb begin
      mdiv_d       = mdiv_q;
      sdiv_d       = sdiv_q;
      mclk_d       = mclk_q;
      sclk_d       = sclk_q;
      lrck_d       = lrck_q;
      sdin_d       = sdin_q;
      underflow_d  = 1'b0;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      left_hold_d  = left_hold_q;
      right_hold_d = right_hold_q;
      left_full_d  = left_full_q;
      right_full_d = right_full_q;

      mdiv_tick = (mdiv_q == MDIV_W'(MCLK_HALF - 1));
      sdiv_tick = (sdiv_q == SDIV_W'(SCLK_HALF - 1));
      fall_evt  = sdiv_tick && sclk_q;

      bit_cnt_nxt = (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
      slot_pos    = (bit_cnt_nxt >= CNT_W'(SLOT_BITS)) ? bit_cnt_nxt - CNT_W'(SLOT_BITS)
                                                       : bit_cnt_nxt;
      load_left   = fall_evt && (bit_cnt_nxt == '0);
      load_right  = fall_evt && (bit_cnt_nxt == CNT_W'(SLOT_BITS));
      left_xfer   = left_valid && !left_full_q;
      right_xfer  = right_valid && right_ready_c;

      // Free-running clock dividers.
      if (mdiv_tick) begin
         mdiv_d = '0;
         mclk_d = !mclk_q;
      end else begin
         mdiv_d = mdiv_q + MDIV_W'(1);
      end
      if (sdiv_tick) begin
         sdiv_d = '0;
         sclk_d = !sclk_q;
      end else begin
         sdiv_d = sdiv_q + SDIV_W'(1);
      end

      // Bit-level work happens only as SCLK falls, keeping SDIN stable at its rising edge.
      if (fall_evt) begin
         bit_cnt_d = bit_cnt_nxt;
         lrck_d    = (bit_cnt_nxt >= CNT_W'(SLOT_BITS));
         sdin_d    = 1'b0;
         if (load_left) begin
            shift_d     = left_full_q ? left_hold_q : '0;
            underflow_d = !left_full_q;
            left_full_d = 1'b0;
         end else if (load_right) begin
            shift_d      = right_full_q ? right_hold_q : '0;
            underflow_d  = !right_full_q;
            right_full_d = 1'b0;
         end else if (slot_pos <= CNT_W'(BIT_DEPTH)) begin
            // Position 0 is the I2S one-bit delay; positions 1..BIT_DEPTH carry MSB..LSB.
            sdin_d  = shift_q[BIT_DEPTH-1];
            shift_d = shift_q << 1;
         end
      end

      // A transfer only happens into an empty holder, so it wins over a same-cycle load.
      if (left_xfer) begin
         left_full_d = 1'b1;
         left_hold_d = pcm_data;
      end
      if (right_xfer) begin
         right_full_d = 1'b1;
         right_hold_d = pcm_data;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mdiv_q       <= '0;
         sdiv_q       <= '0;
         mclk_q       <= 1'b0;
         sclk_q       <= 1'b0;
         lrck_q       <= 1'b1;
         sdin_q       <= 1'b0;
         underflow_q  <= 1'b0;
         bit_cnt_q    <= CNT_W'(FRAME_BITS - 1);
         shift_q      <= '0;
         left_hold_q  <= '0;
         right_hold_q <= '0;
         left_full_q  <= 1'b0;
         right_full_q <= 1'b0;
      end else begin
         mdiv_q       <= mdiv_d;
         sdiv_q       <= sdiv_d;
         mclk_q       <= mclk_d;
         sclk_q       <= sclk_d;
         lrck_q       <= lrck_d;
         sdin_q       <= sdin_d;
         underflow_q  <= underflow_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         left_hold_q  <= left_hold_d;
         right_hold_q <= right_hold_d;
         left_full_q  <= left_full_d;
         right_full_q <= right_full_d;
      end
   end

endmodule
